// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/bubble control of PC and PIPEREG1..4 for the RV32IM 5-stage pipeline.
// Optional macro HAZARD_PERF_EN adds PERF_STALLS / PERF_FLUSHES cycle counters.
module pipeline_hazard_ctrl #(
   parameter int unsigned MULDIV_CYCLES = 33,
   parameter int unsigned CNT_W         = 6
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       IMEM_BUSYWAIT,
   input  logic       DMEM_BUSYWAIT,
   input  logic [4:0] ID_RS1,
   input  logic [4:0] ID_RS2,
   input  logic       ID_USES_RS1,
   input  logic       ID_USES_RS2,
   input  logic [4:0] EX_DESREG,
   input  logic       EX_MEMREAD,
   input  logic       EX_MULDIV,
   input  logic       BRANCH_TAKEN,
   output logic       STALL_PC,
   output logic       STALL_R1,
   output logic       STALL_R2,
   output logic       STALL_R3,
   output logic       STALL_R4,
   output logic       FLUSH_R1,
   output logic       FLUSH_R2,
   output logic       FLUSH_R3,
   output logic       MULDIV_BUSY
`ifdef HAZARD_PERF_EN
   ,
   output logic [31:0] PERF_STALLS,
   output logic [31:0] PERF_FLUSHES
`endif
);

   typedef enum logic [1:0] {RUN, MULDIV, DONE} state_t;

   // Entry cycle plus (load+1) busy cycles gives MULDIV_CYCLES of EX occupancy.
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MULDIV_CYCLES - 2);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             pend_branch;
   logic             pend_lu;
   logic             load_use;
   logic             branch_eff;
   logic             lu_eff;

   assign load_use = EX_MEMREAD && (EX_DESREG != 5'd0) &&
                     ((ID_USES_RS1 && (ID_RS1 == EX_DESREG)) ||
                      (ID_USES_RS2 && (ID_RS2 == EX_DESREG)));

   // Hazards seen during a DMEM wait are remembered and served right after it ends.
   assign branch_eff = BRANCH_TAKEN | pend_branch;
   assign lu_eff     = load_use | pend_lu;

   always_ff @(posedge CLK) begin
      if (!RESET) begin
         state       <= RUN;
         cnt         <= '0;
         pend_branch <= 1'b0;
         pend_lu     <= 1'b0;
      end else begin
         pend_branch <= DMEM_BUSYWAIT & branch_eff;
         pend_lu     <= DMEM_BUSYWAIT & lu_eff;
         unique case (state)
            RUN: begin
               if (EX_MULDIV && !DMEM_BUSYWAIT) begin
                  state <= MULDIV;
                  cnt   <= CNT_LOAD;
               end
            end
            MULDIV: begin
               if (cnt == '0) state <= DONE;
               else           cnt   <= cnt - CNT_W'(1);
            end
            DONE: begin
               if (!DMEM_BUSYWAIT) state <= RUN;
            end
            default: state <= RUN;
         endcase
      end
   end

   // Priority-ordered stall/bubble decode from registered state and live inputs.
   always_comb begin
      STALL_PC    = 1'b0;
      STALL_R1    = 1'b0;
      STALL_R2    = 1'b0;
      STALL_R3    = 1'b0;
      STALL_R4    = 1'b0;
      FLUSH_R1    = 1'b0;
      FLUSH_R2    = 1'b0;
      FLUSH_R3    = 1'b0;
      MULDIV_BUSY = RESET && (state == MULDIV);
      if (!RESET) begin
         FLUSH_R1 = 1'b1;
         FLUSH_R2 = 1'b1;
         FLUSH_R3 = 1'b1;
      end else if (DMEM_BUSYWAIT) begin
         STALL_PC = 1'b1;
         STALL_R1 = 1'b1;
         STALL_R2 = 1'b1;
         STALL_R3 = 1'b1;
         STALL_R4 = 1'b1;
      end else if (state == MULDIV) begin
         STALL_PC = 1'b1;
         STALL_R1 = 1'b1;
         STALL_R2 = 1'b1;
         FLUSH_R3 = 1'b1;
      end else if (branch_eff) begin
         FLUSH_R1 = 1'b1;
         FLUSH_R2 = 1'b1;
      end else if (lu_eff) begin
         STALL_PC = 1'b1;
         STALL_R1 = 1'b1;
         FLUSH_R2 = 1'b1;
      end else if (IMEM_BUSYWAIT) begin
         STALL_PC = 1'b1;
         FLUSH_R1 = 1'b1;
      end
   end

`ifdef HAZARD_PERF_EN
   always_ff @(posedge CLK) begin
      if (!RESET) begin
         PERF_STALLS  <= '0;
         PERF_FLUSHES <= '0;
      end else begin
         if (STALL_PC)                       PERF_STALLS  <= PERF_STALLS + 32'd1;
         if (FLUSH_R1 | FLUSH_R2 | FLUSH_R3) PERF_FLUSHES <= PERF_FLUSHES + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: directed + random stimulus, per-cycle scoreboard against a behavioural model.
// Also checks the HAZARD_PERF_EN counters when that macro is defined.
module tb_pipeline_hazard_ctrl;

   localparam int unsigned MD_CYC = 33;

   typedef struct packed {
      logic       rst;
      logic       imem;
      logic       dmem;
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic       u1;
      logic       u2;
      logic [4:0] des;
      logic       memread;
      logic       muldiv;
      logic       br;
   } stim_t;

   typedef struct {
      logic [8:0] v;
      string      tag;
   } exp_t;

   logic       CLK = 1'b0;
   logic       RESET = 1'b0;
   logic       IMEM_BUSYWAIT = 1'b0, DMEM_BUSYWAIT = 1'b0;
   logic [4:0] ID_RS1 = '0, ID_RS2 = '0, EX_DESREG = '0;
   logic       ID_USES_RS1 = 1'b0, ID_USES_RS2 = 1'b0;
   logic       EX_MEMREAD = 1'b0, EX_MULDIV = 1'b0, BRANCH_TAKEN = 1'b0;
   logic       STALL_PC, STALL_R1, STALL_R2, STALL_R3, STALL_R4;
   logic       FLUSH_R1, FLUSH_R2, FLUSH_R3, MULDIV_BUSY;
`ifdef HAZARD_PERF_EN
   logic [31:0] PERF_STALLS, PERF_FLUSHES;
`endif

   pipeline_hazard_ctrl #(.MULDIV_CYCLES(MD_CYC), .CNT_W(6)) dut (
      .CLK(CLK), .RESET(RESET),
      .IMEM_BUSYWAIT(IMEM_BUSYWAIT), .DMEM_BUSYWAIT(DMEM_BUSYWAIT),
      .ID_RS1(ID_RS1), .ID_RS2(ID_RS2),
      .ID_USES_RS1(ID_USES_RS1), .ID_USES_RS2(ID_USES_RS2),
      .EX_DESREG(EX_DESREG), .EX_MEMREAD(EX_MEMREAD),
      .EX_MULDIV(EX_MULDIV), .BRANCH_TAKEN(BRANCH_TAKEN),
      .STALL_PC(STALL_PC), .STALL_R1(STALL_R1), .STALL_R2(STALL_R2),
      .STALL_R3(STALL_R3), .STALL_R4(STALL_R4),
      .FLUSH_R1(FLUSH_R1), .FLUSH_R2(FLUSH_R2), .FLUSH_R3(FLUSH_R3),
      .MULDIV_BUSY(MULDIV_BUSY)
`ifdef HAZARD_PERF_EN
      , .PERF_STALLS(PERF_STALLS), .PERF_FLUSHES(PERF_FLUSHES)
`endif
   );

   always #5 CLK = ~CLK;

   exp_t exp_q[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   // Reference model: remaining busy cycles of the M op, result-hand-off flag, deferred hazards.
   int          md_left = 0;
   bit          md_done = 1'b0;
   bit          hold_br = 1'b0;
   bit          hold_lu = 1'b0;
   int unsigned m_stalls = 0;
   int unsigned m_flushes = 0;

   function automatic stim_t idle();
      stim_t s = '0;
      s.rst = 1'b1;
      return s;
   endfunction

   task automatic drive(input stim_t s, input string tag);
      exp_t e;
      bit   lu, sp, s1, s2, s3, s4, f1, f2, f3, bz;
      @(posedge CLK);
      #1;
      RESET = s.rst; IMEM_BUSYWAIT = s.imem; DMEM_BUSYWAIT = s.dmem;
      ID_RS1 = s.rs1; ID_RS2 = s.rs2; ID_USES_RS1 = s.u1; ID_USES_RS2 = s.u2;
      EX_DESREG = s.des; EX_MEMREAD = s.memread; EX_MULDIV = s.muldiv; BRANCH_TAKEN = s.br;

      lu = s.memread && (s.des != 0) && ((s.u1 && s.rs1 == s.des) || (s.u2 && s.rs2 == s.des));
      {sp, s1, s2, s3, s4, f1, f2, f3, bz} = '0;
      if (!s.rst)                 {f1, f2, f3} = 3'b111;
      else if (s.dmem)            {sp, s1, s2, s3, s4} = 5'b11111;
      else if (md_left > 0)       {sp, s1, s2, f3} = 4'b1111;
      else if (s.br || hold_br)   {f1, f2} = 2'b11;
      else if (lu || hold_lu)     {sp, s1, f2} = 3'b111;
      else if (s.imem)            {sp, f1} = 2'b11;
      bz = s.rst && (md_left > 0);
      e.v = {sp, s1, s2, s3, s4, f1, f2, f3, bz};
      e.tag = tag;
      exp_q.push_back(e);

      if (!s.rst) begin
         md_left = 0; md_done = 1'b0; hold_br = 1'b0; hold_lu = 1'b0;
         m_stalls = 0; m_flushes = 0;
      end else begin
         m_stalls  += 32'(sp);
         m_flushes += 32'(f1 | f2 | f3);
         hold_br = s.dmem && (hold_br || s.br);
         hold_lu = s.dmem && (hold_lu || lu);
         if (md_left > 0) begin
            md_left--;
            if (md_left == 0) md_done = 1'b1;
         end else if (md_done) begin
            md_done = s.dmem;
         end else if (s.muldiv && !s.dmem) begin
            md_left = MD_CYC - 1;
         end
      end
   endtask

   // Monitor: every cycle the DUT presents outputs; compare against the queued expectation.
   always @(negedge CLK) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         logic [8:0] act;
         e = exp_q.pop_front();
         act = {STALL_PC, STALL_R1, STALL_R2, STALL_R3, STALL_R4,
                FLUSH_R1, FLUSH_R2, FLUSH_R3, MULDIV_BUSY};
         n_tests++;
         if (act !== e.v) begin
            n_fail++;
            $display("FAIL %s t=%0t actual=%b required=%b (stallPC,R1..R4,flushR1..R3,busy)",
                     e.tag, $time, act, e.v);
         end
      end
   end

   initial begin
      stim_t s;
      // T1 / reset state
      s = idle(); s.rst = 1'b0;
      repeat (2) drive(s, "reset");
      // T5 divide occupancy
      s = idle(); s.muldiv = 1'b1; drive(s, "div_start");
      s = idle(); repeat (MD_CYC + 2) drive(s, "div_run");
      // T1 reset during MULDIV
      s = idle(); s.muldiv = 1'b1; drive(s, "div_abort_start");
      s = idle(); repeat (5) drive(s, "div_abort_run");
      s.rst = 1'b0; repeat (2) drive(s, "reset_in_muldiv");
      s = idle(); repeat (2) drive(s, "after_reset");
      // T2 load-use
      s = idle(); s.memread = 1'b1; s.des = 5'd5; s.rs1 = 5'd5; s.rs2 = 5'd1;
      s.u1 = 1'b1; s.u2 = 1'b1; drive(s, "load_use");
      s = idle(); s.rs1 = 5'd5; s.rs2 = 5'd1; s.u1 = 1'b1; s.u2 = 1'b1; drive(s, "load_use_after");
      s = idle(); s.memread = 1'b1; s.des = 5'd7; s.rs2 = 5'd7; s.u2 = 1'b1; drive(s, "load_use_rs2");
      // T3 x0 load
      s = idle(); s.memread = 1'b1; s.des = 5'd0; s.u1 = 1'b1; s.u2 = 1'b1; drive(s, "x0_load");
      // T4 branch over IMEM wait and load-use
      s = idle(); s.br = 1'b1; s.imem = 1'b1; drive(s, "branch_imem");
      s = idle(); s.imem = 1'b1; drive(s, "imem_wait");
      s = idle(); s.br = 1'b1; s.memread = 1'b1; s.des = 5'd3; s.rs1 = 5'd3; s.u1 = 1'b1;
      drive(s, "branch_over_lu");
      // T6 DMEM wait with branch held, then branch still present / branch withdrawn
      s = idle(); s.dmem = 1'b1; s.br = 1'b1; repeat (5) drive(s, "dmem_branch");
      s = idle(); s.br = 1'b1; drive(s, "dmem_branch_release");
      s = idle(); s.dmem = 1'b1; s.br = 1'b1; drive(s, "dmem_branch2");
      s = idle(); s.dmem = 1'b1; repeat (3) drive(s, "dmem_branch2_wait");
      s = idle(); drive(s, "held_branch");
      s = idle(); s.dmem = 1'b1; s.memread = 1'b1; s.des = 5'd9; s.rs1 = 5'd9; s.u1 = 1'b1;
      drive(s, "dmem_lu");
      s = idle(); drive(s, "held_lu");
      // back-to-back M ops, second with DMEM wait stretching DONE
      s = idle(); s.muldiv = 1'b1; drive(s, "b2b_first");
      s = idle(); repeat (MD_CYC - 1) drive(s, "b2b_busy");
      s = idle(); s.muldiv = 1'b1; s.dmem = 1'b1; repeat (2) drive(s, "done_dmem");
      s = idle(); s.muldiv = 1'b1; drive(s, "done_release");
      s = idle(); s.muldiv = 1'b1; drive(s, "b2b_second");
      s = idle(); repeat (MD_CYC + 1) drive(s, "b2b_second_run");
      // random traffic
      for (int i = 0; i < 3000; i++) begin
         s = idle();
         s.rst     = ($urandom_range(0, 199) != 0);
         s.imem    = ($urandom_range(0, 4) == 0);
         s.dmem    = ($urandom_range(0, 5) == 0);
         s.rs1     = 5'($urandom_range(0, 7));
         s.rs2     = 5'($urandom_range(0, 7));
         s.u1      = 1'($urandom_range(0, 1));
         s.u2      = 1'($urandom_range(0, 1));
         s.des     = 5'($urandom_range(0, 7));
         s.memread = ($urandom_range(0, 3) == 0);
         s.muldiv  = ($urandom_range(0, 15) == 0);
         s.br      = ($urandom_range(0, 7) == 0);
         drive(s, "random");
      end
      s = idle(); repeat (MD_CYC + 2) drive(s, "drain");
      @(posedge CLK);
      #1;
`ifdef HAZARD_PERF_EN
      n_tests++;
      if (PERF_STALLS !== m_stalls) begin
         n_fail++;
         $display("FAIL perf_stalls actual=%0d required=%0d", PERF_STALLS, m_stalls);
      end
      n_tests++;
      if (PERF_FLUSHES !== m_flushes) begin
         n_fail++;
         $display("FAIL perf_flushes actual=%0d required=%0d", PERF_FLUSHES, m_flushes);
      end
`endif
      @(negedge CLK);
      #1;
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain actual=%0d required=0 entries", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
